pulse_channel: RTL

- Square-wave voice of the APU, directly downstream of the serial register decoder.
- Consumes the decoded pulse registers 4000/4002/4003 and the decoder's reg_change toggle.
- Produces a 4-bit sample for the mixer, built from an 11-bit period timer, 8-step duty sequencer, envelope and length counter.
- Sweep (register 4001) is not handled here.

---
 rtl/apu_pkg.sv | 26 ++
 rtl/envelope_unit.sv | 58 +++++
 rtl/pulse_channel.sv | 126 ++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared APU constants: length lookup, duty patterns and register field positions.
// Used by the pulse and noise channels.
package apu_pkg;

    localparam int R4000_DUTY_LSB  = 6;
    localparam int R4000_HALT_BIT  = 5;
    localparam int R4000_CONST_BIT = 4;
    localparam int R4003_LEN_LSB   = 3;

    // Listed from index 31 down to index 0 so LEN_TABLE[i] is entry i.
    localparam logic [31:0][7:0] LEN_TABLE = {
        8'd30,  8'd32, 8'd28, 8'd16,  8'd26, 8'd72, 8'd24, 8'd192,
        8'd22,  8'd96, 8'd20, 8'd48,  8'd18, 8'd24, 8'd16, 8'd12,
        8'd14,  8'd26, 8'd12, 8'd14,  8'd10, 8'd60, 8'd8,  8'd160,
        8'd6,   8'd80, 8'd4,  8'd40,  8'd2,  8'd20, 8'd254, 8'd10
    };

    // Bit n of each entry is the output level at sequencer step n.
    localparam logic [3:0][7:0] DUTY_SEQ = {
        8'b1111_1001,
        8'b0001_1110,
        8'b0000_0110,
        8'b0000_0010
    };

endpackage

// File: rtl/envelope_unit.sv
// Volume envelope: restart flag, 4-bit decay level and its divider.
// Produces either the constant volume or the current decay level.
module envelope_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       quarter_tick,
    input  logic       write_evt,
    input  logic [3:0] vol,
    input  logic       loop_en,
    input  logic       const_vol,
    output logic [3:0] level
);

    logic       start_q, start_d;
    logic [3:0] decay_q, decay_d;
    logic [3:0] div_q,   div_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            decay_q <= 4'd0;
            div_q   <= 4'd0;
        end else begin
            start_q <= start_d;
            decay_q <= decay_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        start_d = start_q;
        decay_d = decay_q;
        div_d   = div_q;
        if (quarter_tick) begin
            if (start_q) begin
                start_d = 1'b0;
                decay_d = 4'd15;
                div_d   = vol;
            end else if (div_q == 4'd0) begin
                div_d = vol;
                if (decay_q != 4'd0) begin
                    decay_d = decay_q - 4'd1;
                end else if (loop_en) begin
                    decay_d = 4'd15;
                end
            end else begin
                div_d = div_q - 4'd1;
            end
        end
        // A write landing on a quarter tick is only seen at the following tick.
        if (write_evt) begin
            start_d = 1'b1;
        end
    end

    assign level = const_vol ? vol : decay_q;

endmodule

// File: rtl/pulse_channel.sv
// APU square-wave voice: period timer, duty sequencer, envelope and length counter.
// Register buses are quasi-static; the 4003 write toggle arrives from another clock domain.
module pulse_channel
    import apu_pkg::*;
#(
    parameter int TIMER_W     = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       apu_tick,
    input  logic       quarter_tick,
    input  logic       half_tick,
    input  logic [7:0] reg_4000,
    input  logic [7:0] reg_4002,
    input  logic [7:0] reg_4003,
    input  logic       reg_change,
    output logic [3:0] sample,
    output logic       active
);

    logic [7:0]             reg_4000_q, reg_4002_q, reg_4003_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   extra_q;
    logic                   write_evt;

    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [2:0]             step_q, step_d;
    logic [7:0]             length_q, length_d;
    logic [3:0]             sample_q, sample_d;
    logic                   active_q, active_d;

    logic [TIMER_W-1:0]     period;
    logic [3:0]             vol;
    logic                   halt;
    logic                   duty_bit;
    logic [3:0]             env_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_4000_q <= 8'd0;
            reg_4002_q <= 8'd0;
            reg_4003_q <= 8'd0;
            sync_q     <= '0;
            extra_q    <= 1'b0;
        end else begin
            reg_4000_q <= reg_4000;
            reg_4002_q <= reg_4002;
            reg_4003_q <= reg_4003;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], reg_change};
            extra_q    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign write_evt = sync_q[SYNC_STAGES-1] ^ extra_q;
    assign period    = {reg_4003_q[2:0], reg_4002_q};
    assign vol       = reg_4000_q[3:0];
    assign halt      = reg_4000_q[R4000_HALT_BIT];
    assign duty_bit  = DUTY_SEQ[reg_4000_q[R4000_DUTY_LSB +: 2]][step_q];

    envelope_unit u_env (
        .clk          (clk),
        .rst_n        (rst_n),
        .quarter_tick (quarter_tick),
        .write_evt    (write_evt),
        .vol          (vol),
        .loop_en      (halt),
        .const_vol    (reg_4000_q[R4000_CONST_BIT]),
        .level        (env_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q  <= '0;
            step_q   <= 3'd0;
            length_q <= 8'd0;
            sample_q <= 4'd0;
            active_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            step_q   <= step_d;
            length_q <= length_d;
            sample_q <= sample_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        timer_d  = timer_q;
        step_d   = step_q;
        length_d = length_q;

        if (apu_tick) begin
            if (timer_q == '0) begin
                timer_d = period;
                step_d  = step_q + 3'd1;
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end
        // The sequencer restart overrides any advance; the timer keeps running.
        if (write_evt) begin
            step_d = 3'd0;
        end

        if (!enable) begin
            length_d = 8'd0;
        end else if (write_evt) begin
            length_d = LEN_TABLE[reg_4003_q[R4003_LEN_LSB +: 5]];
        end else if (half_tick && !halt && length_q != 8'd0) begin
            length_d = length_q - 8'd1;
        end

        if (length_q == 8'd0 || period < TIMER_W'(8) || !duty_bit) begin
            sample_d = 4'd0;
        end else begin
            sample_d = env_level;
        end
        active_d = (length_q != 8'd0);
    end

    assign sample = sample_q;
    assign active = active_q;

endmodule
